// File: rtl/line_timing_gen_if.sv
// ----------------------------------------------------------------------------
// line_timing_gen_if : run-enable / line-counter handshake and pixel timing
//                      outputs of the horizontal timing stage
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface line_timing_gen_if #(
  parameter int CNT_W = 6
) ();

  logic             h_enb;
  logic             end_frame;
  logic             new_line;
  logic             lc_enb;
  logic             pix_valid;
  logic [CNT_W-1:0] pix_x;
  logic             frame_done;

  // Timing generator side
  modport master (
    input  h_enb,
    input  end_frame,
    output new_line,
    output lc_enb,
    output pix_valid,
    output pix_x,
    output frame_done
  );

  // Consumer side: run control, line counter and pixel pipeline
  modport slave (
    output h_enb,
    output end_frame,
    input  new_line,
    input  lc_enb,
    input  pix_valid,
    input  pix_x,
    input  frame_done
  );

endinterface

`default_nettype wire

// File: rtl/line_timing_gen.sv
// ----------------------------------------------------------------------------
// line_timing_gen : per-line pixel/blanking timing with vertical blank after
//                   the line counter reports end of frame
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module line_timing_gen #(
  parameter int ACTIVE_PIX = 32,
  parameter int HBLANK     = 8,
  parameter int VBLANK     = 16,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  line_timing_gen_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_HBLANK = 3'd2,
    S_CHECK  = 3'd3,
    S_VBLANK = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_act_last = CNT_W'(ACTIVE_PIX - 1);
  localparam logic [CNT_W-1:0] c_hb_last  = CNT_W'(HBLANK - 1);
  localparam logic [CNT_W-1:0] c_vb_last  = CNT_W'(VBLANK - 1);
  localparam logic [CNT_W-1:0] c_zero     = '0;
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_new_line;
  logic             w_lc_enb;
  logic             w_pix_valid;
  logic [CNT_W-1:0] w_pix_x;
  logic             w_frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= c_zero;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: dropping the run enable returns to IDLE from anywhere,
  // which also holds the line counter cleared through lc_enb.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!bus.h_enb) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = c_zero;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = c_zero;
        end
        S_ACTIVE: begin
          if (r_cnt == c_act_last) begin
            w_state_nxt = S_HBLANK;
            w_cnt_nxt   = c_zero;
          end else begin
            w_cnt_nxt   = r_cnt + c_one;
          end
        end
        S_HBLANK: begin
          if (r_cnt == c_hb_last) begin
            w_state_nxt = S_CHECK;
            w_cnt_nxt   = c_zero;
          end else begin
            w_cnt_nxt   = r_cnt + c_one;
          end
        end
        // end_frame already includes the increment from this line's new_line
        S_CHECK: begin
          w_state_nxt = bus.end_frame ? S_VBLANK : S_ACTIVE;
          w_cnt_nxt   = c_zero;
        end
        S_VBLANK: begin
          if (r_cnt == c_vb_last) begin
            w_state_nxt = S_ACTIVE;
            w_cnt_nxt   = c_zero;
          end else begin
            w_cnt_nxt   = r_cnt + c_one;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = c_zero;
        end
      endcase
    end
  end

  // Outputs depend only on the registered state and counter
  always_comb begin
    w_new_line   = 1'b0;
    w_lc_enb     = 1'b0;
    w_pix_valid  = 1'b0;
    w_pix_x      = c_zero;
    w_frame_done = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        w_lc_enb    = 1'b1;
        w_pix_valid = 1'b1;
        w_pix_x     = r_cnt;
      end
      S_HBLANK: begin
        w_lc_enb   = 1'b1;
        w_new_line = (r_cnt == c_hb_last);
      end
      S_CHECK: begin
        w_lc_enb = 1'b1;
      end
      S_VBLANK: begin
        w_frame_done = (r_cnt == c_vb_last);
      end
      default: begin
        w_lc_enb = 1'b0;
      end
    endcase
  end

  assign bus.new_line   = w_new_line;
  assign bus.lc_enb     = w_lc_enb;
  assign bus.pix_valid  = w_pix_valid;
  assign bus.pix_x      = w_pix_x;
  assign bus.frame_done = w_frame_done;

`ifndef SYNTHESIS
  a_pulse_overlap: assert property (@(posedge clk) disable iff (rst)
    !(w_new_line && w_frame_done));
  a_act_bound: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_ACTIVE) |-> (r_cnt <= c_act_last));
  a_hb_bound: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_HBLANK) |-> (r_cnt <= c_hb_last));
  a_vb_bound: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_VBLANK) |-> (r_cnt <= c_vb_last));
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_line_timing_gen : randomized bench against a position-in-period model,
//                      default geometry plus a minimal 2/1/1 geometry
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_line_timing_gen;

  localparam int A  = 32, H  = 8, V  = 16, W  = 6;
  localparam int A2 = 2,  H2 = 1, V2 = 1,  W2 = 2;
  localparam int LINES = 24;
  localparam int LINE_PER  = A + H + 1;
  localparam int FRAME_PER = LINES * LINE_PER + V;

  logic clk = 1'b0;
  always #8 clk = ~clk;

  logic rst = 1'b1, h_enb = 1'b0, end_frame = 1'b0, end_frame2 = 1'b0;

  line_timing_gen_if #(.CNT_W(W))  bus ();
  line_timing_gen_if #(.CNT_W(W2)) bus2 ();

  assign bus.h_enb      = h_enb;
  assign bus.end_frame  = end_frame;
  assign bus2.h_enb     = h_enb;
  assign bus2.end_frame = end_frame2;

  line_timing_gen #(.ACTIVE_PIX(A), .HBLANK(H), .VBLANK(V), .CNT_W(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  line_timing_gen #(.ACTIVE_PIX(A2), .HBLANK(H2), .VBLANK(V2), .CNT_W(W2)) u_dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Model: running flag, whether in vertical blank, and position within the
  // current line (0..A+H, last slot is the end_frame check) or blank period.
  typedef struct packed { bit run; bit vb; int pos; } mdl_t;
  typedef struct packed { bit nl; bit lc; bit pv; bit fd; int px; } outs_t;

  function automatic mdl_t mdl_step(mdl_t s, bit r, bit en, bit ef, int pa, int ph, int pv);
    mdl_t n = s;
    if (r || !en) begin
      n = '0;
    end else if (!s.run) begin
      n.run = 1'b1; n.vb = 1'b0; n.pos = 0;
    end else if (s.vb) begin
      if (s.pos == pv - 1) begin n.vb = 1'b0; n.pos = 0; end
      else n.pos = s.pos + 1;
    end else begin
      if (s.pos == pa + ph) begin n.vb = ef; n.pos = 0; end
      else n.pos = s.pos + 1;
    end
    return n;
  endfunction

  function automatic outs_t mdl_out(mdl_t s, int pa, int ph, int pv);
    outs_t o = '0;
    if (s.run) begin
      if (s.vb) begin
        o.fd = (s.pos == pv - 1);
      end else begin
        o.lc = 1'b1;
        o.pv = (s.pos < pa);
        o.px = o.pv ? s.pos : 0;
        o.nl = (s.pos == pa + ph - 1);
      end
    end
    return o;
  endfunction

  mdl_t  m = '0, m2 = '0;
  outs_t e = '0, e2 = '0;
  int    n_vec = 0, n_err = 0, cyc = 0;
  int    lc_cnt = 0, lc_nxt = 0;
  bit    glitch_en = 1'b0, trk_en = 1'b0;
  int    last_nl = -1, last_fd = -1, nl_cnt = 0;
  bit    found;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic track();
    if (bus.new_line === 1'b1) begin
      nl_cnt++;
      if (last_nl >= 0) chk("nl_gap", 32'(cyc - last_nl), 32'(LINE_PER));
      last_nl = cyc;
    end
    if (bus.frame_done === 1'b1) begin
      chk("nl_per_frame", 32'(nl_cnt), 32'(LINES));
      if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'(FRAME_PER));
      last_fd = cyc;
      last_nl = -1;
      nl_cnt  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m  = mdl_step(m,  rst, h_enb, end_frame,  A,  H,  V);
    m2 = mdl_step(m2, rst, h_enb, end_frame2, A2, H2, V2);
    lc_cnt = rst ? 0 : lc_nxt;
    #1;
    cyc++;
    e  = mdl_out(m,  A,  H,  V);
    e2 = mdl_out(m2, A2, H2, V2);
    chk("new_line",     32'(bus.new_line),    32'(e.nl));
    chk("lc_enb",       32'(bus.lc_enb),      32'(e.lc));
    chk("pix_valid",    32'(bus.pix_valid),   32'(e.pv));
    chk("pix_x",        32'(bus.pix_x),       32'(e.px));
    chk("frame_done",   32'(bus.frame_done),  32'(e.fd));
    chk("s_new_line",   32'(bus2.new_line),   32'(e2.nl));
    chk("s_lc_enb",     32'(bus2.lc_enb),     32'(e2.lc));
    chk("s_pix_valid",  32'(bus2.pix_valid),  32'(e2.pv));
    chk("s_pix_x",      32'(bus2.pix_x),      32'(e2.px));
    chk("s_frame_done", 32'(bus2.frame_done), 32'(e2.fd));
    // behavioural line counter: cleared while lc_enb low, counts new_line
    lc_nxt = !e.lc ? 0 : (e.nl ? lc_cnt + 1 : lc_cnt);
    if (trk_en) track();
    end_frame = (lc_cnt == LINES) ||
                (glitch_en && !(m.run && !m.vb && m.pos == A + H) && ($urandom_range(0, 1) == 1));
    end_frame2 = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    #(16 * 30000);
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; h_enb = 1'b0;
    repeat (3) tick();

    // free run with line counter: two-plus frames of timing
    rst = 1'b0; h_enb = 1'b1;
    trk_en = 1'b1; last_nl = -1; last_fd = -1; nl_cnt = 0;
    repeat (2 * FRAME_PER + 50) tick();

    // end_frame glitches outside the check slot must be ignored
    glitch_en = 1'b1;
    repeat (FRAME_PER + 20) tick();
    glitch_en = 1'b0;
    trk_en = 1'b0;

    // drop enable at pix_x == 17, then re-raise
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (e.pv && e.px == 17) found = 1'b1;
      else tick();
    end
    chk("find_x17", 32'(found), 32'd1);
    h_enb = 1'b0; tick();
    h_enb = 1'b1; tick();
    repeat (60) tick();

    // reset in the middle of vertical blank
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      if (m.run && m.vb && m.pos == 9) found = 1'b1;
      else tick();
    end
    chk("find_vb9", 32'(found), 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (100) tick();

    // random enable drops and resets, frequent then rare
    repeat (1500) begin
      h_enb = ($urandom_range(0, 99) >= 3);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    repeat (1500) begin
      h_enb = ($urandom_range(0, 999) >= 2);
      rst   = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; h_enb = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
